// File: rtl/rw_reg_master.sv
// Initiator-side sequencer for the two-write-port 16-bit read/write register block.
// Optional write readback check is compiled in with `define RWM_READBACK_EN.
module rw_reg_master #(
  parameter int DW       = 16,
  parameter int READ_LAT = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic             cmd_sel,
  input  logic [DW-1:0]    cmd_data,
  output logic             bus_rw,
  output logic [DW-1:0]    bus_w1,
  output logic [DW-1:0]    bus_w2,
  input  logic [DW-1:0]    bus_read,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_err,
  output logic [CNT_W-1:0] txn_count
);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; the source holds valid and payload stable until that edge.

  localparam int CW = 4;

`ifdef RWM_READBACK_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, CHECK} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP} state_t;
`endif

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          sel_q;
  logic          accept;
  logic [DW-1:0] wdata;

  assign accept = (state == IDLE) && cmd_valid && cmd_ready;
  // The selected write bus already holds the accepted write data.
  assign wdata  = sel_q ? bus_w2 : bus_w1;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_rw) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            cnt_d   = CW'(READ_LAT - 1);
          end
        end
      end
      WRITE: begin
`ifdef RWM_READBACK_EN
        state_d = CHECK;
        cnt_d   = CW'(READ_LAT - 1);
`else
        state_d = RESP;
`endif
      end
      READ: begin
        if (cnt == '0) state_d = RESP;
        else           cnt_d   = cnt - CW'(1);
      end
`ifdef RWM_READBACK_EN
      CHECK: begin
        if (cnt == '0) state_d = RESP;
        else           cnt_d   = cnt - CW'(1);
      end
`endif
      RESP: begin
        if (rsp_valid && rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so reset drives them to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_q     <= 1'b0;
      cmd_ready <= 1'b0;
      bus_rw    <= 1'b0;
      bus_w1    <= '0;
      bus_w2    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      txn_count <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cmd_ready <= (state_d == IDLE);
      bus_rw    <= (state_d == WRITE);
      rsp_valid <= (state_d == RESP);
      if (accept && cmd_rw) begin
        sel_q <= cmd_sel;
        if (cmd_sel) bus_w2 <= cmd_data;
        else         bus_w1 <= cmd_data;
      end
      if (state == WRITE) rsp_data <= wdata;
      if (state == READ && cnt == '0) rsp_data <= bus_read;
`ifdef RWM_READBACK_EN
      if (state == CHECK && cnt == '0) rsp_data <= bus_read;
`endif
      if (rsp_valid && rsp_ready) txn_count <= txn_count + CNT_W'(1);
    end
  end

`ifdef RWM_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else begin
      if (state == READ && cnt == '0)  rsp_err <= 1'b0;
      if (state == CHECK && cnt == '0) rsp_err <= (bus_read != wdata);
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_rw_reg_master.sv
// Bench for rw_reg_master: reset checks, vector table, reset corner cases and
// random transactions against a transaction-level reference model.
module tb_rw_reg_master;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int CW  = 8;
`ifdef RWM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0, cmd_sel = 1'b0;
  logic [DW-1:0] cmd_data = '0, bus_w1, bus_w2, bus_read = '0, rsp_data;
  logic          bus_rw, rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [CW-1:0] txn_count;

  always #5 clk = ~clk;

  rw_reg_master #(.DW(DW), .READ_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_sel(cmd_sel), .cmd_data(cmd_data), .bus_rw(bus_rw),
    .bus_w1(bus_w1), .bus_w2(bus_w2), .bus_read(bus_read), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .txn_count(txn_count)
  );

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] m_w1, m_w2;
  logic [CW-1:0] m_cnt;
  logic [DW-1:0] exp_q[$];
  logic          err_q[$];

  typedef struct {
    logic          rw;
    logic          sel;
    logic [DW-1:0] data;
    logic [DW-1:0] rd;
    int            delay;
    logic [DW-1:0] exp_rsp;
    logic          exp_err;
    logic [DW-1:0] exp_w1;
    logic [DW-1:0] exp_w2;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_bus_rw", bus_rw, 0);
    chk("rst_bus_w1", bus_w1, 0);
    chk("rst_bus_w2", bus_w2, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_txn_count", txn_count, 0);
  endtask

  task automatic model_reset();
    m_w1 = '0;
    m_w2 = '0;
    m_cnt = '0;
    exp_q.delete();
    err_q.delete();
  endtask

  // One full command/response transaction; compares against the model as it goes.
  task automatic txn(input logic rw, input logic sel, input logic [DW-1:0] data,
                     input logic [DW-1:0] rd, input int delay,
                     output logic [DW-1:0] got_d, output logic got_e);
    int lat, want_lat, n;
    logic [DW-1:0] held;
    got_d = '0;
    got_e = 1'b0;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    if (!cmd_ready) return;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_sel = sel; cmd_data = data; bus_read = rd;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (rw) begin
      if (sel) m_w2 = data;
      else     m_w1 = data;
    end
    exp_q.push_back((rw && !RB) ? data : rd);
    err_q.push_back(RB && rw && (rd != data));
    want_lat = rw ? (RB ? LAT + 2 : 2) : LAT + 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      chk("bus_rw", bus_rw, rw && lat == 1);
      chk("bus_w1_hold", bus_w1, m_w1);
      chk("bus_w2_hold", bus_w2, m_w2);
    end while (!rsp_valid && lat < 40);
    chk("rsp_latency", lat, want_lat);
    chk("rsp_data", rsp_data, exp_q.pop_front());
    chk("rsp_err", rsp_err, err_q.pop_front());
    chk("cmd_ready_busy", cmd_ready, 0);
    got_d = rsp_data;
    got_e = rsp_err;
    held = rsp_data;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, held);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_txn_count", txn_count, m_cnt);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    m_cnt = m_cnt + 1'b1;
    @(negedge clk);
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("txn_count", txn_count, m_cnt);
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] gd;
    logic          ge;
    logic [DW-1:0] d, r;
    vecs[0] = '{1'b1, 1'b0, 16'h0001, 16'h0001, 0, 16'h0001, 1'b0, 16'h0001, 16'h0000, 8'd1};
    vecs[1] = '{1'b1, 1'b1, 16'h0002, 16'h0002, 0, 16'h0002, 1'b0, 16'h0001, 16'h0002, 8'd2};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0037, 0, 16'h0037, 1'b0, 16'h0001, 16'h0002, 8'd3};
    vecs[3] = '{1'b0, 1'b1, 16'h5555, 16'h0037, 5, 16'h0037, 1'b0, 16'h0001, 16'h0002, 8'd4};
    vecs[4] = '{1'b1, 1'b0, 16'h0037, 16'h0036, 1, RB ? 16'h0036 : 16'h0037, RB,
                16'h0037, 16'h0002, 8'd5};
    vecs[5] = '{1'b1, 1'b0, 16'h0037, 16'h0037, 0, 16'h0037, 1'b0, 16'h0037, 16'h0002, 8'd6};
    vecs[6] = '{1'b1, 1'b1, 16'hffff, 16'h1234, 2, RB ? 16'h1234 : 16'hffff, RB,
                16'h0037, 16'hffff, 8'd7};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 16'habcd, 0, 16'habcd, 1'b0, 16'h0037, 16'hffff, 8'd8};

    // Power-on reset
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero();
    rst = 1'b0;
    #1 chk("cmd_ready_pre_edge", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_post_rst", cmd_ready, 1);

    // Directed vector table
    foreach (vecs[i]) begin
      txn(vecs[i].rw, vecs[i].sel, vecs[i].data, vecs[i].rd, vecs[i].delay, gd, ge);
      chk($sformatf("vec%0d_rsp", i), gd, vecs[i].exp_rsp);
      chk($sformatf("vec%0d_err", i), ge, vecs[i].exp_err);
      chk($sformatf("vec%0d_w1", i), bus_w1, vecs[i].exp_w1);
      chk($sformatf("vec%0d_w2", i), bus_w2, vecs[i].exp_w2);
      chk($sformatf("vec%0d_cnt", i), txn_count, vecs[i].exp_cnt);
    end

    // Mid-cycle reset while a write is in flight and cmd_valid is high
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_sel = 1'b1; cmd_data = 16'h4242;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero();
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    model_reset();
    @(negedge clk);
    chk("cmd_ready_after_midrst", cmd_ready, 1);

    // Reset during the read wait: no response, no count
    cmd_valid = 1'b1; cmd_rw = 1'b0; bus_read = 16'h0037;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("read_wait_bus_rw", bus_rw, 0);
    chk("read_wait_no_rsp", rsp_valid, 0);
    rst = 1'b1;
    #1 chk("abort_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    chk("abort_txn_count", txn_count, 0);
    chk("abort_cmd_ready", cmd_ready, 1);

    // Random transactions; enough of them to wrap txn_count
    for (int k = 0; k < 300; k++) begin
      d = DW'($urandom);
      r = ($urandom_range(0, 3) == 0) ? d : DW'($urandom);
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, r,
          $urandom_range(0, 3), gd, ge);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
